// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store sequencer.
package lsu_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsuState_e;

    // Load funct3 encodings.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings.
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Cycles allowed in REQ+WAIT before an access is abandoned (valid range 1..255).
    localparam int TIMEOUT_DEFAULT = 255;

    // True when funct3 names a real access of the given direction.
    function automatic logic f3Legal(input logic isStore, input logic [2:0] f3);
        if (isStore) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // True when the byte offset suits the access size in funct3[1:0].
    function automatic logic f3Aligned(input logic [2:0] f3, input logic [1:0] offset);
        case (f3[1:0])
            2'b01:   return ~offset[0];
            2'b10:   return (offset == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_sequencer_if.sv
// Data-bus bundle between the load/store sequencer and the memory system.
//
// Handshake: the master raises bus_req with bus_we/bus_addr/bus_be/bus_wdata
// and holds all of them unchanged until a cycle in which bus_gnt is high;
// that cycle accepts the request and bus_req drops on the next edge. The
// access then completes in the first later cycle with bus_rvalid high
// (bus_rdata carries load data; for stores it is only an acknowledge).
// bus_gnt while no request is pending and bus_rvalid while no response is
// awaited have no effect.
interface lsu_sequencer_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables / data replication on the request
// side, and load extraction with sign or zero extension on the response side.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  reqSize,
    input  logic [1:0]  reqOffset,
    input  logic [31:0] storeData,
    output logic [3:0]  byteEn,
    output logic [31:0] laneData,
    input  logic [2:0]  rspFunct3,
    input  logic [1:0]  rspOffset,
    input  logic [31:0] rspData,
    output logic [31:0] loadResult
);

    logic [31:0] shifted;

    // Byte enables and replicated store data for the access being launched.
    always_comb begin
        byteEn   = 4'b1111;
        laneData = storeData;
        case (reqSize)
            2'b00: begin
                byteEn   = 4'b0001 << reqOffset;
                laneData = {4{storeData[7:0]}};
            end
            2'b01: begin
                byteEn   = 4'b0011 << reqOffset;
                laneData = {2{storeData[15:0]}};
            end
            default: ;
        endcase
    end

    // Move the addressed lane to bit 0, then extend according to the load type.
    always_comb begin
        shifted = rspData >> {rspOffset, 3'b000};
        case (rspFunct3)
            F3_LB:   loadResult = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   loadResult = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  loadResult = {24'd0, shifted[7:0]};
            F3_LHU:  loadResult = {16'd0, shifted[15:0]};
            default: loadResult = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_sequencer.sv
// MEM-stage load/store sequencer: launches one bus transaction per memory
// instruction, stalls the pipeline until it completes or times out, and
// reports misaligned/illegal accesses without touching the bus.
module lsu_sequencer
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic                  mem_write,
    input  logic                  mem_read,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    lsu_sequencer_if.master       bus,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  misalign,
    output logic                  bus_timeout,
    output lsuState_e             dbgState
);

    // The counter holds the number of REQ/WAIT cycles already spent, so the
    // TIMEOUT-th cycle is the one where it equals TIMEOUT-1.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    lsuState_e   state;
    logic [7:0]  cnt;
    logic [2:0]  capFunct3;
    logic [1:0]  capOffset;

    logic        isAccess;
    logic        isStore;
    logic        accessOk;
    logic        start;
    logic        hitLimit;
    logic [3:0]  nextBe;
    logic [31:0] nextWdata;
    logic [31:0] extracted;

    // A read+write collision is treated as a store.
    assign isAccess = mem_valid & (mem_read | mem_write);
    assign isStore  = mem_write;
    assign accessOk = f3Legal(isStore, funct3) & f3Aligned(funct3, addr[1:0]);
    assign start    = isAccess & accessOk;
    assign hitLimit = (cnt == LIMIT);

    // The IDLE term lets the pipeline freeze in the same cycle the access is seen.
    assign stall    = ((state == ST_IDLE) & start) | (state == ST_REQ) | (state == ST_WAIT);
    assign dbgState = state;

    lsu_lane_align uAlign (
        .reqSize    (funct3[1:0]),
        .reqOffset  (addr[1:0]),
        .storeData  (wdata),
        .byteEn     (nextBe),
        .laneData   (nextWdata),
        .rspFunct3  (capFunct3),
        .rspOffset  (capOffset),
        .rspData    (bus.bus_rdata),
        .loadResult (extracted)
    );

    // Sequencer FSM with capture registers, timeout counter and status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cnt           <= 8'd0;
            capFunct3     <= 3'd0;
            capOffset     <= 2'd0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'd0;
            bus.bus_be    <= 4'd0;
            bus.bus_wdata <= 32'd0;
            load_data     <= 32'd0;
            misalign      <= 1'b0;
            bus_timeout   <= 1'b0;
        end else begin
            misalign    <= 1'b0;
            bus_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state         <= ST_REQ;
                        cnt           <= 8'd0;
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= isStore;
                        bus.bus_addr  <= {addr[31:2], 2'b00};
                        bus.bus_be    <= nextBe;
                        bus.bus_wdata <= nextWdata;
                        capFunct3     <= funct3;
                        capOffset     <= addr[1:0];
                    end else if (isAccess) begin
                        misalign <= 1'b1;
                    end
                end
                ST_REQ: begin
                    cnt <= cnt + 8'd1;
                    // A grant in the last allowed cycle leaves no room for the
                    // response, so the limit wins here.
                    if (hitLimit) begin
                        bus.bus_req <= 1'b0;
                        bus_timeout <= 1'b1;
                        state       <= ST_DONE;
                    end else if (bus.bus_gnt) begin
                        bus.bus_req <= 1'b0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (bus.bus_rvalid) begin
                        if (!bus.bus_we) begin
                            load_data <= extracted;
                        end
                        state <= ST_DONE;
                    end else if (hitLimit) begin
                        bus_timeout <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_sequencer.md
# lsu_sequencer

Multi-cycle load/store sequencer for the MEM stage of the RV32I pipelined core. Takes the decoded memory control for the instruction currently in MEM, runs a request/grant/response transaction on the data bus, and holds the pipeline with a stall until the access completes. Generates byte enables, store-data lane replication and load extraction/extension, and flags misaligned/illegal accesses and bus timeouts.

## Interface
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before the access is aborted.
- clk  in  1  core clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- mem_valid  in  1  a valid instruction occupies MEM this cycle.
- mem_write  in  1  decoded MemWrite (store).
- mem_read  in  1  load (decoded ResultSrc == 2'b01).
- funct3  in  3  access size/sign from the instruction.
- addr  in  32  effective byte address (ALU result).
- wdata  in  32  store source register value.
- bus_req  out  1  request; high in REQ only.
- bus_we  out  1  1 = write.
- bus_addr  out  32  {addr[31:2], 2'b00}, captured.
- bus_be  out  4  byte enables, captured.
- bus_wdata  out  32  lane-replicated store data, captured.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  response (read data or write ack) this cycle.
- bus_rdata  in  32  read data, valid with bus_rvalid.
- stall  out  1  freeze all pipeline stages.
- load_data  out  32  extracted, extended load result.
- misalign  out  1  one-cycle pulse: misaligned or illegal-funct3 access.
- bus_timeout  out  1  one-cycle pulse: TIMEOUT expired.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- start = mem_valid & (mem_read | mem_write) & aligned & legal.
- IDLE: start -> capture bus_addr/be/wdata/we and access info, go REQ. Illegal/misaligned access with mem_valid -> misalign pulse next cycle, stay IDLE, no bus cycle.
- REQ: bus_req=1, bus fields stable; bus_gnt -> WAIT.
- WAIT: bus_rvalid -> (load) register load_data, go DONE.
- DONE: single cycle, stall=0 so the pipeline advances; inputs ignored; -> IDLE.
- Timeout: 8-bit counter cleared on leaving IDLE, increments in REQ/WAIT; on reaching TIMEOUT -> bus_timeout pulse, go DONE (load_data unchanged).
- stall = (IDLE & start) | REQ | WAIT (combinational).
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; others illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00.
- bus_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- bus_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load: shift bus_rdata right by 8*captured addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU); LW unmodified.
- bus_rvalid outside WAIT and bus_gnt outside REQ are ignored.
- mem_read & mem_write both high: treated as store.

## Timing
- Reset values: state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, load_data 0, misalign 0, bus_timeout 0, counter 0; stall = 0 until mem_valid observed.
- Zero-wait bus (gnt in first REQ cycle, rvalid the next): stall high 3 cycles (IDLE, REQ, WAIT), DONE on 4th; load_data valid from DONE onward, held until the next load completes.
- Back-to-back accesses: DONE -> IDLE -> new start; no overlap of transactions.
- Reset mid-transaction: immediate abort, bus_req drops asynchronously; outstanding response after reset ignored.
- misalign/bus_timeout are registered, exactly one cycle wide.

## Structure
- Package lsu_pkg: state enum, funct3 encodings (LB..LHU, SB..SW), TIMEOUT default.
- Sub-module lsu_lane_align (combinational): be/wdata generation and load extraction/extension; the sequencer holds FSM, capture registers and counter.

## Test plan
- LW addr 0x100, gnt immediate, rdata 0xDEADBEEF next cycle -> bus_addr 0x100, be 1111, stall 3 cycles, load_data 0xDEADBEEF.
- LB addr 0x103, rdata 0x80FF_0000 -> be 1000, load_data 0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x202, wdata 0x1234ABCD, gnt delayed 2 cycles -> bus_req held 3 cycles stable, be 1100, bus_wdata 0xABCDABCD, bus_we 1.
- LW addr 0x101 -> no bus_req, misalign pulse 1 cycle, stall low next cycle; funct3 011 load -> same.
- No gnt, TIMEOUT=4 -> bus_timeout pulse after 4 cycles, DONE, stall released.
- Reset asserted during WAIT -> bus_req 0, state IDLE, all outputs reset; late rvalid ignored.
